// File: rtl/scale_ctrl.sv
// scale_ctrl: sequencer for the image-scaling engine bank.
// Latches op/factor on start, validates the pair, holds the chosen engine in
// local reset, then runs it with frame-RAM writes gated on. It waits for the
// engine's done, keeps writes open for a short flush window, and then reports
// completion and status.
//
// A scale factor of 8 does not fit in the 3-bit fator field. It is carried as
// 3'b000, which is 8 truncated to three bits.
module scale_ctrl #(
    parameter int RST_CYC   = 2,      // eng_rst_n low cycles in CLEAR (1..15)
    parameter int FLUSH_CYC = 2,      // write-flush cycles after engine done (1..15)
    parameter int TIMEOUT   = 400000  // RUN-cycle limit before abort (< 2^19)
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [2:0]  fator,
    input  logic [3:0]  eng_done,
    output logic        eng_rst_n,
    output logic [3:0]  eng_sel,
    output logic [2:0]  eng_fator,
    output logic        ram_wren,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [18:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [1:0]  ERR_OK      = 2'b00;
    localparam logic [1:0]  ERR_CFG     = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

    localparam logic [3:0]  RST_LAST    = 4'(RST_CYC - 1);
    localparam logic [3:0]  FLUSH_LAST  = 4'(FLUSH_CYC - 1);
    localparam logic [18:0] TIMEOUT_C   = 19'(TIMEOUT);

    state_e      state_q,     state_d;
    logic [1:0]  op_q,        op_d;
    logic [2:0]  fator_q,     fator_d;
    logic [3:0]  eng_sel_q,   eng_sel_d;
    logic [2:0]  eng_fator_q, eng_fator_d;
    logic [1:0]  err_q,       err_d;
    logic [18:0] cycles_q,    cycles_d;
    logic [18:0] run_cnt_q,   run_cnt_d;
    logic [3:0]  phase_cnt_q, phase_cnt_d;

    logic [18:0] run_cnt_inc;

    // Legal pairs: 1/2/4 for any op, 8 (3'b000) for decimate/average only,
    // and passthrough only at factor 1.
    function automatic logic cfg_ok(input logic [1:0] o, input logic [2:0] f);
        logic ok;
        ok = 1'b0;
        case (f)
            3'd1:       ok = 1'b1;
            3'd2, 3'd4: ok = (o != 2'b11);
            3'd0:       ok = (o == 2'b00) || (o == 2'b10);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign run_cnt_inc = run_cnt_q + 19'd1;

    // Next-state and Moore output decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        fator_d     = fator_q;
        eng_sel_d   = eng_sel_q;
        eng_fator_d = eng_fator_q;
        err_d       = err_q;
        cycles_d    = cycles_q;
        run_cnt_d   = run_cnt_q;
        phase_cnt_d = phase_cnt_q;
        eng_rst_n   = 1'b0;
        ram_wren    = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    fator_d = fator;
                    err_d   = ERR_OK;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (cfg_ok(op_q, fator_q)) begin
                    eng_sel_d   = 4'b0001 << op_q;
                    eng_fator_d = fator_q;
                    phase_cnt_d = 4'd0;
                    state_d     = S_CLEAR;
                end else begin
                    err_d   = ERR_CFG;
                    state_d = S_ERR;
                end
            end

            S_CLEAR: begin
                run_cnt_d = 19'd0;
                if (phase_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end else begin
                    phase_cnt_d = phase_cnt_q + 4'd1;
                end
            end

            S_RUN: begin
                eng_rst_n = 1'b1;
                ram_wren  = 1'b1;
                run_cnt_d = run_cnt_inc;
                // Only the selected engine's done bit matters; the count
                // reported includes the cycle in which done was seen.
                if (eng_done[op_q]) begin
                    cycles_d    = run_cnt_inc;
                    phase_cnt_d = 4'd0;
                    state_d     = S_FLUSH;
                end else if (run_cnt_inc == TIMEOUT_C) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end
            end

            S_FLUSH: begin
                // Keep writes open so the engine's final registered write lands.
                eng_rst_n = 1'b1;
                ram_wren  = 1'b1;
                if (phase_cnt_q == FLUSH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            S_ERR: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            fator_q     <= 3'd0;
            eng_sel_q   <= 4'd0;
            eng_fator_q <= 3'd0;
            err_q       <= ERR_OK;
            cycles_q    <= 19'd0;
            run_cnt_q   <= 19'd0;
            phase_cnt_q <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values from before this edge, independent of statement order.
            state_q     <= state_d;
            op_q        <= op_d;
            fator_q     <= fator_d;
            eng_sel_q   <= eng_sel_d;
            eng_fator_q <= eng_fator_d;
            err_q       <= err_d;
            cycles_q    <= cycles_d;
            run_cnt_q   <= run_cnt_d;
            phase_cnt_q <= phase_cnt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign eng_sel   = eng_sel_q;
    assign eng_fator = eng_fator_q;
    assign err       = err_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_scale_ctrl.sv
// tb_scale_ctrl: directed vectors for scale_ctrl plus hand-written multi-cycle
// sequences (foreign done bits, reset in FLUSH, back-to-back start).
// Cycle numbering: the cycle in which start is driven is cycle 0; cycle k is
// the interval after the k-th rising edge from there.
module tb_scale_ctrl;

    localparam int RST_CYC   = 2;
    localparam int FLUSH_CYC = 2;
    localparam int TIMEOUT   = 5000;
    localparam int BUDGET    = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [2:0]  fator = 3'd0;
    logic [3:0]  eng_done = 4'd0;
    logic        eng_rst_n;
    logic [3:0]  eng_sel;
    logic [2:0]  eng_fator;
    logic        ram_wren;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [18:0] cycles;

    int n_cmp = 0;
    int n_bad = 0;

    scale_ctrl #(
        .RST_CYC  (RST_CYC),
        .FLUSH_CYC(FLUSH_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .fator    (fator),
        .eng_done (eng_done),
        .eng_rst_n(eng_rst_n),
        .eng_sel  (eng_sel),
        .eng_fator(eng_fator),
        .ram_wren (ram_wren),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    // One full operation: stimulus plus every expected result, worked by hand.
    // n_run = RUN cycle on which the engine raises done (0 = never).
    typedef struct {
        logic [1:0]  op;
        logic [2:0]  fator;
        int          n_run;
        logic [1:0]  exp_err;
        logic [3:0]  exp_sel;
        logic [2:0]  exp_fator;
        logic [18:0] exp_cycles;
        int          exp_done;
        int          exp_hi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int done_cyc;
        int hi_cnt;
        int wren_cnt;
        int first_hi;
        cyc      = 0;
        done_cyc = -1;
        hi_cnt   = 0;
        wren_cnt = 0;
        first_hi = -1;
        eng_done = 4'd0;
        start    = 1'b1;
        op       = v.op;
        fator    = v.fator;
        for (int k = 0; k < BUDGET; k++) begin
            step();
            cyc++;
            // Inputs change after acceptance and must be ignored.
            start = 1'b0;
            op    = ~v.op;
            fator = ~v.fator;
            if (v.n_run > 0 && cyc >= 3 + v.n_run) eng_done[v.op] = 1'b1;
            if (eng_rst_n) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = cyc;
            end
            if (ram_wren) wren_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d err", idx), {30'd0, err}, {30'd0, v.exp_err});
        check($sformatf("v%0d cycles", idx), {13'd0, cycles}, {13'd0, v.exp_cycles});
        check($sformatf("v%0d eng_sel", idx), {28'd0, eng_sel}, {28'd0, v.exp_sel});
        check($sformatf("v%0d eng_fator", idx), {29'd0, eng_fator}, {29'd0, v.exp_fator});
        check($sformatf("v%0d eng_rst_n_hi_cnt", idx), hi_cnt, v.exp_hi);
        check($sformatf("v%0d ram_wren_hi_cnt", idx), wren_cnt, v.exp_hi);
        check($sformatf("v%0d eng_rst_n_first", idx), first_hi, (v.exp_hi > 0) ? 4 : -1);
        eng_done = 4'd0;
        step();
        check($sformatf("v%0d busy_after", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d done_after", idx), {31'd0, done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        vec_t post_rst;
        int   cyc;
        int   d1;
        int   d2;
        int   sel_bad;
        int   saw_done;

        // op, fator, n_run, err, sel, fator_out, cycles, done_cycle, hi_cycles
        vecs[0]  = '{2'd0, 3'd2, 4800, 2'b00, 4'b0001, 3'd2, 19'd4800, 4806, 4802};
        vecs[1]  = '{2'd1, 3'd0, 0,    2'b01, 4'b0001, 3'd2, 19'd4800, 2,    0};
        vecs[2]  = '{2'd3, 3'd2, 0,    2'b01, 4'b0001, 3'd2, 19'd4800, 2,    0};
        vecs[3]  = '{2'd2, 3'd0, 10,   2'b00, 4'b0100, 3'd0, 19'd10,   16,   12};
        vecs[4]  = '{2'd1, 3'd4, 3,    2'b00, 4'b0010, 3'd4, 19'd3,    9,    5};
        vecs[5]  = '{2'd3, 3'd1, 5,    2'b00, 4'b1000, 3'd1, 19'd5,    11,   7};
        vecs[6]  = '{2'd0, 3'd3, 0,    2'b01, 4'b1000, 3'd1, 19'd5,    2,    0};
        vecs[7]  = '{2'd2, 3'd7, 0,    2'b01, 4'b1000, 3'd1, 19'd5,    2,    0};
        vecs[8]  = '{2'd2, 3'd4, 0,    2'b10, 4'b0100, 3'd4, 19'd5,    5004, 5000};
        vecs[9]  = '{2'd0, 3'd0, 1,    2'b00, 4'b0001, 3'd0, 19'd1,    7,    3};
        vecs[10] = '{2'd1, 3'd1, 2,    2'b00, 4'b0010, 3'd1, 19'd2,    8,    4};
        post_rst = '{2'd1, 3'd2, 7,    2'b00, 4'b0010, 3'd2, 19'd7,    13,   9};

        // Reset state.
        #1;
        check("rst eng_rst_n", {31'd0, eng_rst_n}, 32'd0);
        check("rst eng_sel", {28'd0, eng_sel}, 32'd0);
        check("rst eng_fator", {29'd0, eng_fator}, 32'd0);
        check("rst ram_wren", {31'd0, ram_wren}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst err", {30'd0, err}, 32'd0);
        check("rst cycles", {13'd0, cycles}, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        check("post_rst busy", {31'd0, busy}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Foreign done bits, start toggling and op/fator changes during RUN.
        eng_done = 4'd0;
        start = 1'b1;
        op    = 2'd0;
        fator = 3'd1;
        cyc = 0;
        d1 = -1;
        sel_bad = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            cyc++;
            start = (cyc >= 5 && cyc <= 25) ? cyc[0] : 1'b0;
            op    = 2'd3;
            fator = 3'd2;
            eng_done = (cyc >= 5) ? 4'b1010 : 4'b0000;
            if (cyc >= 23) eng_done[0] = 1'b1;
            if (cyc >= 3 && eng_sel != 4'b0001) sel_bad++;
            if (done) begin
                d1 = cyc;
                break;
            end
        end
        check("foreign done_cycle", d1, 26);
        check("foreign sel_stable", sel_bad, 0);
        check("foreign cycles", {13'd0, cycles}, 32'd20);
        check("foreign eng_fator", {29'd0, eng_fator}, 32'd1);
        check("foreign err", {30'd0, err}, 32'd0);
        eng_done = 4'd0;
        step();
        check("foreign idle_after", {31'd0, busy}, 32'd0);

        // Reset asserted in FLUSH: done seen at cycle 8, FLUSH in cycles 9-10.
        start = 1'b1;
        op    = 2'd0;
        fator = 3'd2;
        for (int k = 1; k <= 9; k++) begin
            step();
            start = 1'b0;
            if (k >= 8) eng_done[0] = 1'b1;
        end
        check("flush ram_wren_before", {31'd0, ram_wren}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("flush_rst eng_rst_n", {31'd0, eng_rst_n}, 32'd0);
        check("flush_rst ram_wren", {31'd0, ram_wren}, 32'd0);
        check("flush_rst busy", {31'd0, busy}, 32'd0);
        check("flush_rst eng_sel", {28'd0, eng_sel}, 32'd0);
        check("flush_rst eng_fator", {29'd0, eng_fator}, 32'd0);
        check("flush_rst err_cycles", {11'd0, err, cycles}, 32'd0);
        saw_done = 0;
        eng_done = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (done) saw_done++;
            step();
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (done) saw_done++;
            step();
        end
        check("flush_rst no_done", saw_done, 0);
        run_vec(post_rst, 100);

        // Done already high on the first RUN cycle; start held for a relaunch.
        eng_done = 4'b1000;
        start = 1'b1;
        op    = 2'd3;
        fator = 3'd1;
        cyc = 0;
        d1 = -1;
        d2 = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            cyc++;
            if (cyc >= 15) start = 1'b0;
            if (cyc == 4) check("b2b eng_rst_n_rise", {31'd0, eng_rst_n}, 32'd1);
            if (cyc == 8) check("b2b idle_between", {31'd0, busy}, 32'd0);
            if (cyc == 9) check("b2b relaunch_busy", {31'd0, busy}, 32'd1);
            if (done && d1 < 0) d1 = cyc;
            else if (done && d2 < 0) d2 = cyc;
        end
        check("b2b first_done", d1, 7);
        check("b2b second_done", d2, 15);
        check("b2b cycles", {13'd0, cycles}, 32'd1);
        check("b2b err", {30'd0, err}, 32'd0);
        check("b2b idle_end", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
